// File: rtl/pll_lock_controller.sv
// PLL loop-filter sequencer: measures phase-detector activity per window, switches
// the filter between acquisition and tracking gains, reports lock and retries on timeout.
`timescale 1ns/1ps

module pll_lock_controller #(
   parameter int                 WINDOW              = 64,
   parameter int                 ACT_LOCK_MAX        = 2,
   parameter int                 ACT_UNLOCK_MIN      = 8,
   parameter int                 LOCK_WINDOWS        = 4,
   parameter int                 UNLOCK_WINDOWS      = 2,
   parameter int                 ACQ_TIMEOUT_WINDOWS = 256,
   parameter int                 MAX_RETRIES         = 3,
   parameter logic signed [15:0] KP_ACQ              = 16'sd7,
   parameter logic signed [15:0] KI_ACQ              = 16'sd4,
   parameter logic signed [15:0] KP_TRK              = 16'sd2,
   parameter logic signed [15:0] KI_TRK              = 16'sd1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               up,
   input  logic               down,
   output logic signed [15:0] kp,
   output logic signed [15:0] ki,
   output logic               lpf_clear,
   output logic               locked,
   output logic               fail,
   output logic [2:0]         state,
   output logic [3:0]         retry_cnt
);

   localparam int WW = $clog2(WINDOW);
   localparam int AW = $clog2(WINDOW + 1);
   localparam int QW = $clog2(LOCK_WINDOWS + 1);
   localparam int NW = $clog2(UNLOCK_WINDOWS + 1);
   localparam int TW = $clog2(ACQ_TIMEOUT_WINDOWS + 1);

   localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
   localparam logic [AW-1:0] QUIET_MAX  = AW'(ACT_LOCK_MAX);
   localparam logic [AW-1:0] NOISY_MIN  = AW'(ACT_UNLOCK_MIN);
   localparam logic [QW-1:0] LOCK_CNT   = QW'(LOCK_WINDOWS);
   localparam logic [NW-1:0] UNLOCK_CNT = NW'(UNLOCK_WINDOWS);
   localparam logic [TW-1:0] TIMEOUT    = TW'(ACQ_TIMEOUT_WINDOWS);
   localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_ACQUIRE = 3'd2,
      S_TRACK   = 3'd3,
      S_FAIL    = 3'd4
   } state_e;

   state_e        state_q,  state_d;
   logic [WW-1:0] win_q,    win_d;
   logic [AW-1:0] act_q,    act_d;
   logic [QW-1:0] quiet_q,  quiet_d;
   logic [NW-1:0] noisy_q,  noisy_d;
   logic [TW-1:0] acqwin_q, acqwin_d;
   logic [3:0]    retry_q,  retry_d;

   logic          active;
   logic          win_end;
   logic [AW-1:0] act_total;
   logic [QW-1:0] quiet_inc;
   logic [NW-1:0] noisy_inc;
   logic [TW-1:0] acqwin_inc;

   // Window evaluation includes the activity of the final window cycle itself.
   always_comb begin
      active     = up ^ down;
      win_end    = (win_q == WIN_LAST);
      act_total  = act_q + AW'(active);
      quiet_inc  = (act_total <= QUIET_MAX) ? quiet_q + 1'b1 : '0;
      noisy_inc  = (act_total >= NOISY_MIN) ? noisy_q + 1'b1 : '0;
      acqwin_inc = acqwin_q + 1'b1;
   end

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it
      // unassigned; a missing default here would infer a latch.
      state_d  = state_q;
      win_d    = '0;
      act_d    = '0;
      quiet_d  = quiet_q;
      noisy_d  = noisy_q;
      acqwin_d = acqwin_q;
      retry_d  = retry_q;

      if (!enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_CLEAR;
               retry_d = '0;
            end

            S_CLEAR: begin
               state_d  = S_ACQUIRE;
               quiet_d  = '0;
               noisy_d  = '0;
               acqwin_d = '0;
            end

            S_ACQUIRE: begin
               win_d = win_q + 1'b1;
               act_d = win_end ? '0 : act_total;
               if (win_end) begin
                  quiet_d  = quiet_inc;
                  acqwin_d = acqwin_inc;
                  // Lock is tested first so it wins over a coincident timeout.
                  if (quiet_inc == LOCK_CNT) begin
                     state_d = S_TRACK;
                     quiet_d = '0;
                     noisy_d = '0;
                  end else if (acqwin_inc == TIMEOUT) begin
                     if (retry_q == RETRY_MAX) begin
                        state_d = S_FAIL;
                     end else begin
                        state_d = S_CLEAR;
                        retry_d = retry_q + 1'b1;
                     end
                  end
               end
            end

            S_TRACK: begin
               win_d = win_q + 1'b1;
               act_d = win_end ? '0 : act_total;
               if (win_end) begin
                  noisy_d = noisy_inc;
                  if (noisy_inc == UNLOCK_CNT) begin
                     state_d  = S_ACQUIRE;
                     noisy_d  = '0;
                     quiet_d  = '0;
                     acqwin_d = '0;
                  end
               end
            end

            S_FAIL: state_d = S_FAIL;

            default: state_d = S_IDLE;
         endcase
      end

      // A new state always starts a fresh measurement window.
      if (state_d != state_q) begin
         win_d = '0;
         act_d = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples its _d value from the same edge regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         win_q    <= '0;
         act_q    <= '0;
         quiet_q  <= '0;
         noisy_q  <= '0;
         acqwin_q <= '0;
         retry_q  <= '0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         act_q    <= act_d;
         quiet_q  <= quiet_d;
         noisy_q  <= noisy_d;
         acqwin_q <= acqwin_d;
         retry_q  <= retry_d;
      end
   end

   // Moore decode straight from the state register, so reset reaches the outputs asynchronously.
   always_comb begin
      kp        = (state_q == S_TRACK) ? KP_TRK : KP_ACQ;
      ki        = (state_q == S_TRACK) ? KI_TRK : KI_ACQ;
      lpf_clear = (state_q == S_IDLE) || (state_q == S_CLEAR) || (state_q == S_FAIL);
      locked    = (state_q == S_TRACK);
      fail      = (state_q == S_FAIL);
      state     = state_q;
      retry_cnt = retry_q;
   end

endmodule
